// File: rtl/seg7_pkg.sv
// Shared definitions for the scanned seven-segment display driver.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
package seg7_pkg;

    // Segment bit positions within the 7-bit segment bus {g,f,e,d,c,b,a}.
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Active-high segment patterns for hex digits 0..F. Index 0 is the first entry.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // One display position: decimal point plus hex nibble.
    typedef struct packed {
        logic       dp;
        logic [3:0] hex;
    } digit_t;

    // Level an output sits at when it is switched off.
    function automatic logic inactive_level(input bit active_low);
        return active_low;
    endfunction

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational hex nibble to active-high seven-segment pattern.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: hex - 4-bit digit value; seg - {g,f,e,d,c,b,a}, 1 = segment lit.
module hex7seg_decode
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[hex];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with guard blanking and leading-zero suppression.
// Latency: outputs registered, one cycle behind the scan counters; a write shows after the next edge.
// Backpressure: none; writes always accepted, ena=0 freezes the scan and blanks the outputs.
// Ports: clk/rst_n (async active-low), ena scan enable, lzs zero suppression,
//        wr_en/wr_addr/wr_data digit write {dp,hex}, seg/dp/dig_sel display lines,
//        frame_tick one-cycle pulse after each completed frame.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter  int DIGITS     = 4,
    parameter  int CLK_DIV    = 1000,
    parameter  int GUARD      = 2,
    parameter  int ACTIVE_LOW = 0,
    localparam int AW         = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              lzs,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [4:0]        wr_data,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [DIGITS-1:0] dig_sel,
    output logic              frame_tick
);

    localparam int   PW  = $clog2(CLK_DIV);
    localparam logic INV = inactive_level(ACTIVE_LOW != 0);

    logic [PW-1:0]     pre;
    logic [AW-1:0]     idx;
    digit_t            regs [DIGITS];

    logic              pre_last;
    logic              idx_last;
    logic              active;
    logic              suppress;
    logic              wr_ok;
    digit_t            cur;
    logic [6:0]        seg_dec;
    logic [DIGITS-1:0] keep;
    logic [6:0]        seg_n;
    logic              dp_n;
    logic [DIGITS-1:0] sel_n;

    assign pre_last = (pre == PW'(CLK_DIV - 1));
    assign idx_last = (idx == AW'(DIGITS - 1));
    assign active   = ena && (pre >= PW'(GUARD));
    // Widen by one bit so DIGITS equal to 2**AW still compares correctly.
    assign wr_ok    = wr_en && ({1'b0, wr_addr} < (AW + 1)'(DIGITS));
    assign cur      = regs[idx];

    hex7seg_decode u_decode (
        .hex (cur.hex),
        .seg (seg_dec)
    );

    // keep[i] is set when any digit at or above i is non-zero (prefix-OR from the MSB down).
    always_comb begin
        logic acc;
        acc  = 1'b0;
        keep = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            acc     = acc | (regs[i].hex != 4'd0);
            keep[i] = acc;
        end
    end

    assign suppress = lzs && (idx != '0) && !keep[idx];

    always_comb begin
        seg_n = '0;
        dp_n  = 1'b0;
        sel_n = '0;
        if (active) begin
            sel_n = DIGITS'(1) << idx;
            dp_n  = cur.dp;
            if (!suppress) begin
                seg_n = seg_dec;
            end
        end
    end

    // Scan counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
            idx <= '0;
        end else if (ena) begin
            if (pre_last) begin
                pre <= '0;
                idx <= idx_last ? '0 : idx + 1'b1;
            end else begin
                pre <= pre + 1'b1;
            end
        end
    end

    // Digit register file; writes are independent of the scan enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Output registers; polarity applied last so blanking lands on the inactive level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= {7{INV}};
            dp         <= INV;
            dig_sel    <= {DIGITS{INV}};
            frame_tick <= 1'b0;
        end else begin
            seg        <= seg_n ^ {7{INV}};
            dp         <= dp_n ^ INV;
            dig_sel    <= sel_n ^ {DIGITS{INV}};
            frame_tick <= ena && pre_last && idx_last;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (4-digit active-high, 6-digit active-low)
// compared every cycle against a count-based behavioural model, plus literal spot checks.
module tb_seg7_scan_driver;

    localparam int CD = 8;
    localparam int GD = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       ena;
    logic       lzs;
    logic       wr_en_a;
    logic [1:0] wr_addr_a;
    logic [4:0] wr_data_a;
    logic       wr_en_b;
    logic [2:0] wr_addr_b;
    logic [4:0] wr_data_b;

    logic [6:0] seg_a;
    logic       dp_a;
    logic [3:0] dig_sel_a;
    logic       ft_a;
    logic [6:0] seg_b;
    logic       dp_b;
    logic [5:0] dig_sel_b;
    logic       ft_b;

    seg7_scan_driver #(.DIGITS(4), .CLK_DIV(CD), .GUARD(GD), .ACTIVE_LOW(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .lzs(lzs),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .seg(seg_a), .dp(dp_a), .dig_sel(dig_sel_a), .frame_tick(ft_a)
    );

    seg7_scan_driver #(.DIGITS(6), .CLK_DIV(CD), .GUARD(GD), .ACTIVE_LOW(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .lzs(lzs),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .seg(seg_b), .dp(dp_b), .dig_sel(dig_sel_b), .frame_tick(ft_b)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit checking    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, expv);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The scan position is derived from a count of enabled cycles since reset.
    logic [6:0] dec_tbl [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    logic [4:0] regs_m [2][8];
    int         en_count;
    logic [6:0] exp_seg [2];
    logic       exp_dp  [2];
    logic [7:0] exp_sel [2];
    logic       exp_ft  [2];

    function automatic int ndig(input int k);
        return (k == 0) ? 4 : 6;
    endfunction

    function automatic int m_idx(input int k);
        return (en_count / CD) % ndig(k);
    endfunction

    function automatic bit m_active();
        return ena && ((en_count % CD) >= GD);
    endfunction

    function automatic logic [6:0] m_seg(input int k);
        logic [6:0] s;
        bit all_zero;
        int ix;
        s = 7'h00;
        all_zero = 1;
        ix = m_idx(k);
        if (m_active()) begin
            for (int j = ix; j < ndig(k); j++)
                if (regs_m[k][j][3:0] != 4'd0) all_zero = 0;
            if (!(lzs && ix > 0 && all_zero)) s = dec_tbl[regs_m[k][ix][3:0]];
        end
        return (k == 1) ? ~s : s;
    endfunction

    function automatic logic m_dp(input int k);
        logic d;
        d = m_active() ? regs_m[k][m_idx(k)][4] : 1'b0;
        return (k == 1) ? ~d : d;
    endfunction

    function automatic logic [7:0] m_sel(input int k);
        logic [7:0] v;
        v = m_active() ? (8'd1 << m_idx(k)) : 8'd0;
        return (k == 1) ? (~v & 8'h3F) : v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_count <= 0;
            for (int k = 0; k < 2; k++) begin
                for (int j = 0; j < 8; j++) regs_m[k][j] <= 5'd0;
                exp_seg[k] <= (k == 1) ? 7'h7F : 7'h00;
                exp_dp[k]  <= (k == 1);
                exp_sel[k] <= (k == 1) ? 8'h3F : 8'h00;
                exp_ft[k]  <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                exp_seg[k] <= m_seg(k);
                exp_dp[k]  <= m_dp(k);
                exp_sel[k] <= m_sel(k);
                exp_ft[k]  <= ena && ((en_count % (CD * ndig(k))) == CD * ndig(k) - 1);
            end
            if (ena) en_count <= en_count + 1;
            if (wr_en_a) regs_m[0][wr_addr_a] <= wr_data_a;
            if (wr_en_b && wr_addr_b < 3'd6) regs_m[1][wr_addr_b] <= wr_data_b;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (checking) begin
            chk("seg_a",     seg_a,     exp_seg[0]);
            chk("dp_a",      dp_a,      exp_dp[0]);
            chk("dig_sel_a", dig_sel_a, exp_sel[0][3:0]);
            chk("ft_a",      ft_a,      exp_ft[0]);
            chk("seg_b",     seg_b,     exp_seg[1]);
            chk("dp_b",      dp_b,      exp_dp[1]);
            chk("dig_sel_b", dig_sel_b, exp_sel[1][5:0]);
            chk("ft_b",      ft_b,      exp_ft[1]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr_a(input int a, input int d);
        wr_en_a   = 1'b1;
        wr_addr_a = a[1:0];
        wr_data_a = d[4:0];
        @(negedge clk);
        wr_en_a   = 1'b0;
    endtask

    task automatic wr_b(input int a, input int d);
        wr_en_b   = 1'b1;
        wr_addr_b = a[2:0];
        wr_data_b = d[4:0];
        @(negedge clk);
        wr_en_b   = 1'b0;
    endtask

    task automatic wait_sel_a(input logic [3:0] v, input int budget);
        int n;
        n = 0;
        while (dig_sel_a !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait dig_sel_a", dig_sel_a, v);
    endtask

    task automatic wait_sel_b(input logic [5:0] v, input int budget);
        int n;
        n = 0;
        while (dig_sel_b !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait dig_sel_b", dig_sel_b, v);
    endtask

    task automatic wait_ft_a(output int t);
        int n;
        n = 0;
        @(negedge clk);
        while (ft_a !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("frame_tick_a seen", ft_a, 1);
        t = cyc;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int t0, t1, n, cnt;
        rst_n = 1'b0; ena = 1'b0; lzs = 1'b0;
        wr_en_a = 1'b0; wr_addr_a = '0; wr_data_a = '0;
        wr_en_b = 1'b0; wr_addr_b = '0; wr_data_b = '0;

        // Reset values with the clock running.
        tick(3);
        checking = 1;
        chk("rst seg_a", seg_a, 7'h00);
        chk("rst dp_a", dp_a, 0);
        chk("rst dig_sel_a", dig_sel_a, 4'b0000);
        chk("rst ft_a", ft_a, 0);
        chk("rst seg_b", seg_b, 7'h7F);
        chk("rst dig_sel_b", dig_sel_b, 6'h3F);
        chk("rst dp_b", dp_b, 1);

        // Release: first lit digit appears GUARD+1 edges later on digit 0.
        rst_n = 1'b1; ena = 1'b1;
        tick(1); chk("edge1 dig_sel_a", dig_sel_a, 4'b0000);
        tick(1); chk("edge2 dig_sel_a", dig_sel_a, 4'b0000);
        tick(1); chk("edge3 dig_sel_a", dig_sel_a, 4'b0001);
        chk("edge3 seg_a", seg_a, 7'h3F);

        // Scan order and values; out-of-range write on the 6-digit instance.
        for (int i = 0; i < 4; i++) wr_a(i, i + 1);
        wr_b(0, 1);
        wr_b(7, 5'h1F);
        tick(1);
        wait_sel_a(4'b0010, 64); chk("digit1 seg_a", seg_a, 7'h5B);
        wait_sel_a(4'b0100, 64); chk("digit2 seg_a", seg_a, 7'h4F);
        wait_sel_a(4'b1000, 64); chk("digit3 seg_a", seg_a, 7'h66);
        wait_sel_b(6'h3E, 100);  chk("digit0 seg_b", seg_b, 7'h79);
        wait_sel_b(6'h1F, 100);  chk("digit5 seg_b", seg_b, 7'h40);
        wait_ft_a(t0);
        wait_ft_a(t1);
        chk("frame period", t1 - t0, 32);

        // Leading-zero suppression with {d3..d0} = {0,0,7,0}.
        wr_a(0, 0); wr_a(1, 7); wr_a(2, 0); wr_a(3, 0);
        lzs = 1'b1;
        tick(1);
        wait_sel_a(4'b1000, 64); chk("lzs d3", seg_a, 7'h00);
        wait_sel_a(4'b0100, 64); chk("lzs d2", seg_a, 7'h00);
        wait_sel_a(4'b0010, 64); chk("lzs d1", seg_a, 7'h07);
        wait_sel_a(4'b0001, 64); chk("lzs d0", seg_a, 7'h3F);
        lzs = 1'b0;
        tick(1);
        wait_sel_a(4'b1000, 64); chk("no lzs d3", seg_a, 7'h3F);

        // ena freeze at pre=4 of digit 1.
        n = 0;
        while (!((en_count % CD) == 4 && ((en_count / CD) % 4) == 1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach pre4 digit1", en_count % CD, 4);
        ena = 1'b0;
        tick(1); chk("freeze blank", dig_sel_a, 4'b0000);
        tick(4);
        ena = 1'b1;
        cnt = 0;
        @(negedge clk);
        while (dig_sel_a == 4'b0010 && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        chk("resume digit1 cycles", cnt, 4);

        // Randomised traffic.
        for (int c = 0; c < 1500; c++) begin
            wr_en_a   = ($urandom_range(0, 3) == 0);
            wr_addr_a = 2'($urandom_range(0, 3));
            wr_data_a = 5'($urandom);
            wr_en_b   = ($urandom_range(0, 3) == 0);
            wr_addr_b = 3'($urandom_range(0, 7));
            wr_data_b = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom);
            if ($urandom_range(0, 63) == 0) lzs = ~lzs;
            ena = ($urandom_range(0, 15) != 0);
            @(negedge clk);
        end
        wr_en_a = 1'b0; wr_en_b = 1'b0; ena = 1'b1;

        // Asynchronous reset between edges while digit 2 is lit.
        wait_sel_a(4'b0100, 64);
        #2 rst_n = 1'b0;
        #1;
        chk("async seg_a", seg_a, 7'h00);
        chk("async dig_sel_a", dig_sel_a, 4'b0000);
        chk("async dig_sel_b", dig_sel_b, 6'h3F);
        chk("async ft_a", ft_a, 0);
        tick(2);
        rst_n = 1'b1; lzs = 1'b0;
        wait_sel_a(4'b1000, 64); chk("post rst d3", seg_a, 7'h3F);
        wait_sel_b(6'h1F, 100);  chk("post rst b d5", seg_b, 7'h40);
        tick(10);

        checking = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed seven-segment display driver for the TinyTapeout CPU top level. It holds one hex digit and decimal point per display position and scans them onto shared segment lines, one digit at a time. It inserts a blanking dead-time between digits to prevent ghosting and supports optional leading-zero suppression. It replaces the single-digit direct `segments = uo_out[6:0]` drive with an N-digit scanned display.

## Interface
- `DIGITS`, 4: number of display positions, 1..8; index 0 is the least significant digit.
- `CLK_DIV`, 1000: clock cycles per digit slot, at least 4.
- `GUARD`, 2: blanking cycles at the start of each slot, 1..CLK_DIV-2.
- `ACTIVE_LOW`, 0: 1 inverts `seg`, `dp` and `dig_sel`, so inactive is all ones.
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: scan enable; the TinyTapeout design-select signal.
- `lzs` in 1: leading-zero suppression enable.
- `wr_en` in 1: digit write strobe.
- `wr_addr` in AW: digit index, where AW = max(1, $clog2(DIGITS)).
- `wr_data` in 5: write payload, {dp, hex[3:0]}.
- `seg` out 7: segment lines {g,f,e,d,c,b,a}.
- `dp` out 1: decimal point.
- `dig_sel` out DIGITS: one-hot digit enable.
- `frame_tick` out 1: one-cycle pulse per completed scan frame.

## Operation
- **State**
  - Prescaler `pre` counts 0..CLK_DIV-1.
  - Digit index `idx` counts 0..DIGITS-1.
  - Digit register file holds DIGITS × 5 bits.
- **Scan**
  - While `ena`=1, `pre` increments every cycle.
  - At `pre`=CLK_DIV-1, `pre` wraps to 0 and `idx` advances, wrapping from DIGITS-1 to 0.
  - While `ena`=0, `pre` and `idx` hold.
- **Blanking**: when `pre` < GUARD, or when `ena`=0, all outputs are inactive.
- **Display**: otherwise `dig_sel` is one-hot at bit `idx`, `seg` = decode(hex[idx]) and `dp` = dp[idx].
- **Decode table**, 0..F, active-high: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- **Leading-zero suppression**
  - When `lzs`=1, digit i>0 has `seg` forced to 0 if hex[j]=0 for every j ≥ i.
  - `dig_sel` and `dp` are unaffected by suppression.
  - Digit 0 is never suppressed.
- **Writes**
  - `wr_en`=1 with `wr_addr` < DIGITS writes `wr_data` into register `wr_addr`.
  - Out-of-range addresses are ignored; these exist only when DIGITS is not a power of two.
  - Writes are accepted regardless of `ena`.
- **Polarity**: ACTIVE_LOW=1 bitwise-inverts `seg`, `dp` and `dig_sel` after all other logic.
- **Frame tick**: `frame_tick` is high for exactly the cycle after each edge at which `idx` wraps from DIGITS-1 to 0.
- **Degenerate case**: with DIGITS=1, `idx` stays 0 and `frame_tick` pulses every CLK_DIV cycles.

## Timing
- **Reset state** (applies immediately on `rst_n` low, no clock edge needed):
  - `pre`, `idx` and all digit registers are 0.
  - `frame_tick` is 0.
  - `seg`, `dp` and `dig_sel` are inactive: all 0, or all 1 when ACTIVE_LOW=1.
- **Output registering**
  - All outputs are registered.
  - The value after edge N is the function of `pre`, `idx`, registers, `lzs` and `ena` as they stood before edge N.
  - Outputs therefore lag the counters by one cycle.
- **Write-to-display latency**
  - A write at edge N is visible on the outputs after edge N+1, if that digit is being displayed.
  - A write in the same cycle as a slot change is treated like any other; registers are never stale by more than one cycle.
- **Slot timing**
  - Each slot is GUARD inactive cycles followed by CLK_DIV-GUARD active cycles.
  - A frame lasts DIGITS × CLK_DIV cycles.
- **`ena` changes**
  - When `ena` falls mid-slot, outputs are inactive from the next edge.
  - When `ena` rises again, scanning resumes from the held `pre`/`idx`, with no re-guard beyond the normal GUARD rule.
- **Reset mid-frame**: asserting `rst_n` mid-frame aborts the scan. After release, the first active output appears GUARD+1 enabled edges later, on digit 0.

## Structure
- **Package `seg7_pkg`**:
  - the 16-entry hex-to-segment constant table;
  - the segment bit-order localparams (SEG_A=0 … SEG_G=6);
  - the inactive-level helper function keyed on ACTIVE_LOW.
- **Sub-module `hex7seg_decode`**: combinational 4-bit to 7-bit decode using the package table. It is instantiated once, on the muxed digit.
- **Top**:
  - counters;
  - register file;
  - suppression prefix logic, computed as a prefix-OR of non-zero flags from the MSB down;
  - output registers.

## Test plan
All cases use DIGITS=4, CLK_DIV=8, GUARD=2 unless stated.

1. **Reset values**: hold `rst_n`=0 with `clk` toggling → `seg`=0, `dp`=0, `dig_sel`=0000, `frame_tick`=0. Release with `ena`=1 → first `dig_sel`=0001 with `seg`=3F appears 3 edges after release.
2. **Scan order**: write 1,2,3,4 to addresses 0..3 → `dig_sel` steps 0001/0010/0100/1000. Each is active 6 cycles with `seg` = 06/5B/4F/66 respectively, separated by 2 blank cycles. `frame_tick` pulses every 32 cycles.
3. **Leading-zero suppression**: registers {d3..d0}={0,0,7,0}, `lzs`=1 → `seg`=00 on digits 3 and 2, 07 on digit 1, 3F on digit 0. With `lzs`=0, digits 3 and 2 show 3F.
4. **`ena` freeze**: drop `ena` for 5 cycles at `pre`=4 of digit 1 → outputs inactive after 1 edge. On resume, digit 1 shows for exactly 4 more cycles before its slot ends.
5. **Active-low / out-of-range write** (ACTIVE_LOW=1, DIGITS=6):
   - after reset, `seg`=7F and `dig_sel`=3F;
   - digit 0 = 1 → `seg`=79;
   - a write to `wr_addr`=7 leaves all registers unchanged.
6. **Asynchronous reset mid-slot**: pull `rst_n` low between edges while digit 2 is active → outputs inactive with no clock edge, and all registers read back 0 afterwards.
